// File: rtl/uart_rx_mmio_pkg.sv
// Shared defines, register map and payload types for uart_rx_mmio.
// Optional feature macro: UART_RX_PARITY_EN (even-parity bit after data bit 7).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef UART_DIV
`define UART_DIV 16
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h0000_1000
`endif
`ifndef IO_UART_RX_OFFSET
`define IO_UART_RX_OFFSET 32'h0000_0010
`endif
`ifndef IO_UART_RXSTAT_OFFSET
`define IO_UART_RXSTAT_OFFSET 32'h0000_0014
`endif
`ifndef RXSTAT_NE_BIT
`define RXSTAT_NE_BIT 0
`define RXSTAT_OVR_BIT 1
`define RXSTAT_FERR_BIT 2
`define RXSTAT_PERR_BIT 3
`define RXSTAT_OCC_LSB 4
`endif

package uart_rx_mmio_pkg;
  localparam int unsigned XLEN          = `XLEN;
  localparam int unsigned ADDR_W        = `ADDR_W;
  localparam int unsigned UART_DIV_DFLT = `UART_DIV;

  localparam logic [ADDR_W-1:0] RX_DATA_ADDR = ADDR_W'(`IO_BASE_ADDR + `IO_UART_RX_OFFSET);
  localparam logic [ADDR_W-1:0] RX_STAT_ADDR = ADDR_W'(`IO_BASE_ADDR + `IO_UART_RXSTAT_OFFSET);

  localparam int unsigned STAT_NE      = `RXSTAT_NE_BIT;
  localparam int unsigned STAT_OVR     = `RXSTAT_OVR_BIT;
  localparam int unsigned STAT_FERR    = `RXSTAT_FERR_BIT;
  localparam int unsigned STAT_PERR    = `RXSTAT_PERR_BIT;
  localparam int unsigned STAT_OCC_LSB = `RXSTAT_OCC_LSB;

  // RX_DATA read word: valid flag above the received byte
  typedef struct packed {
    logic [XLEN-10:0] pad;
    logic             valid;
    logic [7:0]       data;
  } rx_data_t;
endpackage

// File: rtl/uart_rx_mmio_if.sv
// MMIO request/response bundle for uart_rx_mmio.
interface uart_rx_mmio_if;
  import uart_rx_mmio_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;
  logic              ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy counter; push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_full_c,
  output logic             o_empty_c,
  output logic [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty_c = (r_count == '0);
  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty_c;
  assign w_do_push = i_push & (~o_full_c | w_do_pop);
  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage write
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_mmio.sv
// UART receiver with receive FIFO and MMIO RX_DATA / RX_STAT registers.
// Optional feature macro: UART_RX_PARITY_EN.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int unsigned UART_DIV   = UART_DIV_DFLT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rx,
  uart_rx_mmio_if.slave mmio
);
  localparam int unsigned CNT_W  = $clog2(UART_DIV);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  logic              r_sync1, r_sync2, r_hist;
  logic              w_line, w_start_edge, w_cnt_zero;
  logic [2:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]        r_bit_idx, w_bit_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_par_bad, w_par_bad_nxt;
  logic              w_push, w_ferr_set, w_perr_set;
  logic              r_ovr, r_ferr, r_perr;
  logic              w_rd, w_wr, w_hit_data, w_hit_stat, w_pop, w_ovr_set;
  logic              w_clr_ovr, w_clr_ferr, w_clr_perr;
  logic [7:0]        w_fifo_rdata;
  logic              w_full, w_empty;
  logic [FCNT_W-1:0] w_fifo_count;
  logic [31:0]       w_count_ext;
  logic [3:0]        w_occ;
  rx_data_t          w_rx_word;
  logic [XLEN-1:0]   w_rdata_nxt, r_rdata;
  logic              w_unused;

  assign w_line       = r_sync2;
  assign w_start_edge = r_hist & ~r_sync2;
  assign w_cnt_zero   = (r_cnt == '0);

  // Line synchronizer plus history flop for start-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Receiver state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_par_bad <= w_par_bad_nxt;
    end
  end

  // Next-state logic: mid-bit sampling driven by the bit-time counter
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_par_bad_nxt = r_par_bad;
    w_push        = 1'b0;
    w_ferr_set    = 1'b0;
    w_perr_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt   = ST_START;
          w_cnt_nxt     = CNT_W'(UART_DIV / 2 - 1);
          w_par_bad_nxt = 1'b0;
        end
      end
      ST_START: begin
        if (!w_cnt_zero) w_cnt_nxt = r_cnt - CNT_W'(1);
        else if (!w_line) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = CNT_W'(UART_DIV - 1);
          w_bit_nxt   = '0;
        end else w_state_nxt = ST_IDLE;
      end
      ST_DATA: begin
        if (!w_cnt_zero) w_cnt_nxt = r_cnt - CNT_W'(1);
        else begin
          w_shift_nxt = {w_line, r_shift[7:1]};
          w_cnt_nxt   = CNT_W'(UART_DIV - 1);
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else w_bit_nxt = r_bit_idx + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (!w_cnt_zero) w_cnt_nxt = r_cnt - CNT_W'(1);
        else begin
          if (w_line != ^r_shift) begin
            w_par_bad_nxt = 1'b1;
            w_perr_set    = 1'b1;
          end
          w_cnt_nxt   = CNT_W'(UART_DIV - 1);
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (!w_cnt_zero) w_cnt_nxt = r_cnt - CNT_W'(1);
        else begin
          w_state_nxt = ST_IDLE;
          if (w_line) w_push = ~r_par_bad;
          else        w_ferr_set = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (r_shift),
    .o_rdata_c (w_fifo_rdata),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_fifo_count)
  );

  assign mmio.ready = mmio.req;
  assign w_rd       = mmio.req & ~mmio.we;
  assign w_wr       = mmio.req & mmio.we;
  assign w_hit_data = (mmio.addr == RX_DATA_ADDR);
  assign w_hit_stat = (mmio.addr == RX_STAT_ADDR);
  assign w_pop      = w_rd & w_hit_data & ~w_empty;
  assign w_ovr_set  = w_push & w_full & ~w_pop;
  assign w_clr_ovr  = w_wr & w_hit_stat & mmio.wdata[STAT_OVR];
  assign w_clr_ferr = w_wr & w_hit_stat & mmio.wdata[STAT_FERR];
  assign w_clr_perr = w_wr & w_hit_stat & mmio.wdata[STAT_PERR];
  assign w_unused   = ^{mmio.wdata[XLEN-1:STAT_PERR+1], mmio.wdata[STAT_NE]};

  assign w_count_ext = 32'(w_fifo_count);
  assign w_occ       = (w_count_ext > 32'd15) ? 4'd15 : w_count_ext[3:0];
  assign w_rx_word   = '{pad: '0, valid: 1'b1, data: w_fifo_rdata};

  // Read data mux; unmapped or empty RX_DATA reads return zero
  always_comb begin
    w_rdata_nxt = '0;
    if (w_hit_data) begin
      if (!w_empty) w_rdata_nxt = w_rx_word;
    end else if (w_hit_stat) begin
      w_rdata_nxt[STAT_NE]            = ~w_empty;
      w_rdata_nxt[STAT_OVR]           = r_ovr;
      w_rdata_nxt[STAT_FERR]          = r_ferr;
      w_rdata_nxt[STAT_PERR]          = r_perr;
      w_rdata_nxt[STAT_OCC_LSB +: 4]  = w_occ;
    end
  end

  // Sticky flags (set wins over W1C) and registered read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ovr  <= w_ovr_set  | (r_ovr  & ~w_clr_ovr);
      r_ferr <= w_ferr_set | (r_ferr & ~w_clr_ferr);
      r_perr <= w_perr_set | (r_perr & ~w_clr_perr);
      if (w_rd) r_rdata <= w_rdata_nxt;
    end
  end

  assign mmio.rdata = r_rdata;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Scoreboard bench for uart_rx_mmio (UART_DIV=16, FIFO_DEPTH=4).
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_mmio;
  import uart_rx_mmio_pkg::*;

  localparam int unsigned DIV   = 16;
  localparam int unsigned DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  // posedge index (1-based from driving the start bit) at which the stop bit is evaluated:
  // 2 sync flops + 1 edge cycle, half a bit to mid-start, then one bit time per bit
  localparam int unsigned STOP_EVAL = 3 + DIV / 2 + DIV * (NBITS - 1);

  logic clk = 1'b0;
  logic rst_n;
  logic uart_rx;
  always #5 clk = ~clk;

  uart_rx_mmio_if mmio ();

  uart_rx_mmio #(.UART_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .mmio    (mmio)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mq[$];
  bit          m_ovr, m_ferr, m_perr;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        rd_fire = 1'b0;
  logic [31:0] last_exp = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_stat();
    return {24'b0, 4'(mq.size()), m_perr, m_ferr, m_ovr, mq.size() != 0};
  endfunction

  function automatic logic [31:0] model_pop();
    if (mq.size() == 0) return 32'h0;
    return 32'h100 | 32'(mq.pop_front());
  endfunction

  function automatic void push_exp(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    exp_q.push_back(e);
    last_exp = exp;
  endfunction

  // Read response monitor: rdata is valid the cycle after the request is sampled
  always @(posedge clk) rd_fire <= mmio.req & ~mmio.we;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, mmio.rdata, e.exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mmio_read(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    @(negedge clk);
    mmio.req  = 1'b1;
    mmio.we   = 1'b0;
    mmio.addr = addr;
    push_exp(tag, exp);
    @(negedge clk);
    mmio.req  = 1'b0;
  endtask

  task automatic rd_data(input string tag);
    mmio_read(RX_DATA_ADDR, tag, model_pop());
  endtask

  task automatic rd_stat(input string tag);
    mmio_read(RX_STAT_ADDR, tag, model_stat());
  endtask

  task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mmio.req   = 1'b1;
    mmio.we    = 1'b1;
    mmio.addr  = addr;
    mmio.wdata = data;
    @(negedge clk);
    mmio.req   = 1'b0;
    mmio.we    = 1'b0;
    if (addr == RX_STAT_ADDR) begin
      if (data[1]) m_ovr  = 1'b0;
      if (data[2]) m_ferr = 1'b0;
      if (data[3]) m_perr = 1'b0;
    end
  endtask

  // Serialises one frame; optionally issues an RX_DATA read on the stop-sample cycle
  task automatic send_frame(input logic [7:0] data, input bit stop, input bit par, input bit pop_at_stop);
    logic [NBITS-1:0] bits;
    bit               par_bad;
`ifdef UART_RX_PARITY_EN
    bits = {stop, par, data, 1'b0};
`else
    bits = {stop, data, 1'b0};
`endif
    par_bad = (par != ^data);
`ifndef UART_RX_PARITY_EN
    par_bad = 1'b0;
`endif
    for (int g = 0; g < int'(NBITS * DIV); g++) begin
      @(negedge clk);
      uart_rx = bits[g / DIV];
      if (pop_at_stop && g == int'(STOP_EVAL) - 1) begin
        mmio.req  = 1'b1;
        mmio.we   = 1'b0;
        mmio.addr = RX_DATA_ADDR;
        push_exp("pop_at_stop", model_pop());
      end else if (pop_at_stop && g == int'(STOP_EVAL)) begin
        mmio.req = 1'b0;
      end
    end
    @(negedge clk);
    uart_rx = 1'b1;
    if (!stop) m_ferr = 1'b1;
    if (par_bad) m_perr = 1'b1;
    if (stop && !par_bad) begin
      if (mq.size() < int'(DEPTH)) mq.push_back(data);
      else m_ovr = 1'b1;
    end
    idle(DIV);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    uart_rx    = 1'b1;
    mmio.req   = 1'b1;
    mmio.we    = 1'b1;
    mmio.addr  = '0;
    mmio.wdata = '0;
    idle(3);
    #1;
    check("ready_in_reset", 32'(mmio.ready), 32'd1);
    check("rdata_reset", mmio.rdata, 32'h0);
    mmio.req = 1'b0;
    mmio.we  = 1'b0;
    #1;
    check("ready_idle", 32'(mmio.ready), 32'd0);
    rst_n = 1'b1;
    idle(4);
    rd_stat("reset_stat");
    rd_data("reset_data_empty");

    // Single good frame
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    rd_stat("stat_a5");
    rd_data("data_a5");
    rd_stat("stat_after_a5");
    rd_data("data_a5_empty");
    mmio_read(RX_DATA_ADDR + 32'h100, "unmapped", 32'h0);
    mmio_write(RX_DATA_ADDR, 32'h0000_01FF);
    idle(3);
    check("rdata_hold", mmio.rdata, last_exp);
    rd_stat("stat_after_data_write");

    // Overrun on fifth frame with no reads
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, ^8'(i), 1'b0);
    rd_stat("stat_overrun");
    for (int i = 0; i < 5; i++) rd_data("drain_ovr");
    rd_stat("stat_ovr_drained");
    mmio_write(RX_STAT_ADDR, 32'h2);
    rd_stat("stat_ovr_cleared");

    // Framing error
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
    rd_stat("stat_ferr");
    rd_data("data_ferr_empty");
    mmio_write(RX_STAT_ADDR, 32'h4);
    rd_stat("stat_ferr_cleared");

    // Short low glitch is rejected, next frame still received
    repeat (5) begin
      @(negedge clk);
      uart_rx = 1'b0;
    end
    @(negedge clk);
    uart_rx = 1'b1;
    idle(3 * DIV);
    rd_stat("stat_glitch");
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
    rd_data("data_after_glitch");

    // Full FIFO with pop coinciding with the fifth stop sample
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, ^(8'h10 + 8'(i)), 1'b0);
    rd_stat("stat_full");
    send_frame(8'h14, 1'b1, ^8'h14, 1'b1);
    rd_stat("stat_push_pop_full");
    for (int i = 0; i < 4; i++) rd_data("drain_full");

    // Reset in the middle of a frame
    begin
      logic [9:0] fb;
      fb = {1'b1, 8'h81, 1'b0};
      for (int g = 0; g < int'(5 * DIV); g++) begin
        @(negedge clk);
        uart_rx = fb[g / DIV];
      end
    end
    rst_n = 1'b0;
    uart_rx = 1'b1;
    idle(2);
    rst_n = 1'b1;
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    check("rdata_after_reset", mmio.rdata, 32'h0);
    idle(2 * DIV);
    rd_stat("stat_mid_frame_reset");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    rd_stat("stat_parity_err");
    rd_data("data_parity_err");
    mmio_write(RX_STAT_ADDR, 32'h8);
    rd_stat("stat_parity_cleared");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    rd_data("data_parity_ok");
`endif

    idle(4);
    if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_mmio.md
UART_RX_MMIO -- requirements
Module: uart_rx_mmio

Interface
REQ-001 Parameter UART_DIV, default `UART_DIV; clocks per bit, ≥4.
REQ-002 Parameter FIFO_DEPTH, default 4; receive FIFO entries, power of two, ≥2.
REQ-003 clk  input  1  single clock; all state on posedge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 mmio_req, mmio_we  input  1 each  access request; write when mmio_we=1.
REQ-006 mmio_addr  input  `ADDR_W  byte address.
REQ-007 mmio_wdata  input  `XLEN  write data.
REQ-008 mmio_rdata  output  `XLEN  read data, registered.
REQ-009 mmio_ready  output  1  access acknowledge.
REQ-010 uart_rx  input  1  asynchronous serial line, idle high.

Function
REQ-011 Register map: RX_DATA at `IO_BASE_ADDR+`IO_UART_RX_OFFSET; RX_STAT at `IO_BASE_ADDR+`IO_UART_RXSTAT_OFFSET.
REQ-012 mmio_ready SHALL equal mmio_req (no wait states); mmio_rdata updates the cycle after a read and holds otherwise; unmapped reads return 0.
REQ-013 uart_rx SHALL pass a 2-flop synchronizer plus one history flop; a start is the synchronized 1->0 transition seen in IDLE.
REQ-014 FSM states: IDLE, START, DATA, (PARITY under REQ-030), STOP.
REQ-015 IDLE->START on start edge; bit counter loaded with UART_DIV/2-1.
REQ-016 START: at counter 0, line low -> DATA with counter UART_DIV-1 and bit index 0; line high -> IDLE (glitch, no flag).
REQ-017 DATA: sample at each counter 0, shift LSB first, reload UART_DIV-1; after bit 7 -> STOP (or PARITY).
REQ-018 STOP: sample at counter 0; high -> push byte; low -> set frame_err, discard byte; either way -> IDLE the same cycle.
REQ-019 Push with FIFO full and no pop that cycle: byte dropped, overrun set, FIFO unchanged.
REQ-020 Push and pop in the same cycle SHALL both occur; no overrun even when full.
REQ-021 Read RX_DATA: returns {0, valid, byte[7:0]} with valid at bit 8, then pops one entry; empty -> returns 0, no pop, pointers unchanged.
REQ-022 Read RX_STAT: bit0 not-empty, bit1 overrun, bit2 frame_err, bit3 parity_err, bits[7:4] occupancy (saturating at 15), others 0.
REQ-023 Write RX_STAT: bits 1–3 written as 1 clear the matching sticky flag (W1C); a same-cycle set wins over a clear.
REQ-024 Writes to RX_DATA SHALL be ignored; FIFO pointers wrap modulo FIFO_DEPTH, with occupancy held in a log2(FIFO_DEPTH)+1-bit counter.

Reset
REQ-025 Under rst_n=0 at posedge: FSM=IDLE, FIFO empty, flags 0, mmio_rdata=0, synchronizer and history flops =1.
REQ-026 Reset mid-frame SHALL abandon the frame; no push and no flag.
REQ-027 mmio_ready SHALL follow mmio_req during reset as well.

Configuration
REQ-028 Macro UART_RX_PARITY_EN selects the parity feature.
REQ-029 Without the macro: frame = start + 8 data + stop; parity_err reads 0.
REQ-030 With the macro: an even-parity bit follows bit 7 (PARITY state, one bit time); a mismatch sets parity_err and discards the byte, and STOP is still checked.

Structure
REQ-031 Register offsets `IO_UART_RX_OFFSET and `IO_UART_RXSTAT_OFFSET, plus the RX_STAT bit-position constants, SHALL live in the shared defines.vh; the FSM state encoding stays local.
REQ-032 The FIFO SHALL be a sub-module sync_fifo (params WIDTH, DEPTH; push, pop, full, empty, count).

Verification (bench: UART_DIV=16, FIFO_DEPTH=4)
REQ-033 Frame 0xA5 with stop=1 -> RX_STAT=0x11; RX_DATA read -> 0x1A5; RX_STAT then 0x00.
REQ-034 Five frames 0x01..0x05 with no reads -> overrun=1; reads return 0x101..0x104, then 0x000.
REQ-035 Frame 0x3C with stop=0 -> frame_err=1, FIFO empty; write RX_STAT 0x4 -> reads 0x00.
REQ-036 Low pulse of 5 clocks on uart_rx -> no push, no flags, FSM back in IDLE.
REQ-037 FIFO full, pop on the same cycle as the 5th stop-bit sample -> no overrun; occupancy stays 4.
REQ-038 UART_RX_PARITY_EN defined: 0x07 with parity bit 0 -> parity_err=1, no push; with parity 1 -> pushed.
